// File: rtl/wb_openram_arbiter.sv
// wb_openram_arbiter: two Wishbone slave ports sharing one OpenRAM RW port.
// Round-robin grant; issue/wait/ack sequencing hides the SRAM read latency.
module wb_openram_arbiter #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int LAT_WIDTH      = 4
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [LAT_WIDTH-1:0]      lat_cycles,

    input  logic                      wbs_m0_cyc_i,
    input  logic                      wbs_m0_stb_i,
    input  logic                      wbs_m0_we_i,
    input  logic [3:0]                wbs_m0_sel_i,
    input  logic [31:0]               wbs_m0_dat_i,
    input  logic [RAM_ADDR_WIDTH+1:0] wbs_m0_adr_i,
    output logic                      wbs_m0_ack_o,
    output logic [31:0]               wbs_m0_dat_o,

    input  logic                      wbs_m1_cyc_i,
    input  logic                      wbs_m1_stb_i,
    input  logic                      wbs_m1_we_i,
    input  logic [3:0]                wbs_m1_sel_i,
    input  logic [31:0]               wbs_m1_dat_i,
    input  logic [RAM_ADDR_WIDTH+1:0] wbs_m1_adr_i,
    output logic                      wbs_m1_ack_o,
    output logic [31:0]               wbs_m1_dat_o,

    output logic                      ram_csb0,
    output logic                      ram_web0,
    output logic [3:0]                ram_wmask0,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr0,
    output logic [31:0]               ram_din0,
    input  logic [31:0]               ram_dout0,

    output logic [1:0]                grant_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t state_q, state_d;

    logic                 req0, req1;
    logic                 pick1;
    logic                 grant_en;
    logic                 g_cyc;
    logic                 last_m1;
    logic                 we_q;
    logic                 leave_busy;
    logic                 enter_ack;
    logic                 sel_we;
    logic [LAT_WIDTH-1:0] cnt_q;
    logic [31:0]          dat_q;
    logic                 unused_adr_bits;

    assign req0 = wbs_m0_cyc_i & wbs_m0_stb_i;
    assign req1 = wbs_m1_cyc_i & wbs_m1_stb_i;

    // On a tie the port that did not win last time is chosen
    assign pick1 = req1 & (~req0 | ~last_m1);

    assign g_cyc = (grant_o[0] & wbs_m0_cyc_i)
                 | (grant_o[1] & wbs_m1_cyc_i);

    assign sel_we = pick1 ? wbs_m1_we_i : wbs_m0_we_i;

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (!g_cyc)
                    state_d = IDLE;
                else if (we_q || cnt_q == '0)
                    state_d = ACK;
                else
                    state_d = WAIT;
            end
            WAIT: begin
                if (!g_cyc)
                    state_d = IDLE;
                else if (cnt_q == LAT_WIDTH'(1))
                    state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign leave_busy = (state_q != IDLE) && (state_d == IDLE);
    assign enter_ack  = (state_q != ACK) && (state_d == ACK);

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            grant_o    <= '0;
            last_m1    <= 1'b1;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            ram_addr0  <= '0;
            ram_din0   <= '0;
            ram_wmask0 <= '0;
            dat_q      <= '0;
        end else begin
            if (grant_en) begin
                grant_o   <= {pick1, ~pick1};
                last_m1   <= pick1;
                we_q      <= sel_we;
                cnt_q     <= lat_cycles;
                ram_addr0 <= pick1 ? wbs_m1_adr_i[RAM_ADDR_WIDTH+1:2]
                                   : wbs_m0_adr_i[RAM_ADDR_WIDTH+1:2];
                ram_din0  <= pick1 ? wbs_m1_dat_i : wbs_m0_dat_i;
                if (sel_we)
                    ram_wmask0 <= pick1 ? wbs_m1_sel_i : wbs_m0_sel_i;
                else
                    ram_wmask0 <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - LAT_WIDTH'(1);
            end
            if (leave_busy) begin
                grant_o    <= '0;
                ram_wmask0 <= '0;
            end
            if (enter_ack && !we_q)
                dat_q <= ram_dout0;
        end
    end

    assign ram_csb0 = (state_q != ISSUE);
    assign ram_web0 = (state_q == ISSUE) ? ~we_q : 1'b1;
    assign busy_o   = (state_q != IDLE);

    assign wbs_m0_ack_o = (state_q == ACK) & grant_o[0];
    assign wbs_m1_ack_o = (state_q == ACK) & grant_o[1];
    assign wbs_m0_dat_o = dat_q;
    assign wbs_m1_dat_o = dat_q;

    // Byte-lane bits of the address never reach the word-addressed SRAM
    assign unused_adr_bits = &{1'b0, wbs_m0_adr_i[1:0], wbs_m1_adr_i[1:0]};

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// tb_wb_openram_arbiter: directed scoreboard bench for wb_openram_arbiter.
// Expected acks are queued by stimulus and popped by a negedge monitor.
module tb_wb_openram_arbiter;

    localparam int AW = 8;
    localparam int LW = 4;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [LW-1:0] lat;

    logic          cyc [2];
    logic          stb [2];
    logic          we  [2];
    logic [3:0]    sel [2];
    logic [31:0]   wdat[2];
    logic [AW+1:0] adr [2];

    logic          ack0, ack1;
    logic [31:0]   rd0, rd1;

    logic          ram_csb0, ram_web0;
    logic [3:0]    ram_wmask0;
    logic [AW-1:0] ram_addr0;
    logic [31:0]   ram_din0;
    logic [31:0]   ram_dout0;
    logic [1:0]    grant_o;
    logic          busy_o;

    logic [31:0]   mem [256];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    exp_t          exp_q[$];
    int            checks;
    int            errors;
    int            cyc_n;

    int            csb_cnt;
    int            csb_cyc;
    logic          iss_web;
    logic [3:0]    iss_mask;
    logic [AW-1:0] iss_addr;
    logic [31:0]   iss_din;

    wb_openram_arbiter #(
        .RAM_ADDR_WIDTH(AW),
        .LAT_WIDTH(LW)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .lat_cycles  (lat),
        .wbs_m0_cyc_i(cyc[0]),
        .wbs_m0_stb_i(stb[0]),
        .wbs_m0_we_i (we[0]),
        .wbs_m0_sel_i(sel[0]),
        .wbs_m0_dat_i(wdat[0]),
        .wbs_m0_adr_i(adr[0]),
        .wbs_m0_ack_o(ack0),
        .wbs_m0_dat_o(rd0),
        .wbs_m1_cyc_i(cyc[1]),
        .wbs_m1_stb_i(stb[1]),
        .wbs_m1_we_i (we[1]),
        .wbs_m1_sel_i(sel[1]),
        .wbs_m1_dat_i(wdat[1]),
        .wbs_m1_adr_i(adr[1]),
        .wbs_m1_ack_o(ack1),
        .wbs_m1_dat_o(rd1),
        .ram_csb0    (ram_csb0),
        .ram_web0    (ram_web0),
        .ram_wmask0  (ram_wmask0),
        .ram_addr0   (ram_addr0),
        .ram_din0    (ram_din0),
        .ram_dout0   (ram_dout0),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc_n = 0;
        forever begin
            @(posedge clk);
            cyc_n = cyc_n + 1;
        end
    end

    // SRAM model on the inverted clock: mid-cycle sample of ISSUE inputs
    always @(negedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!ram_csb0) begin
            if (!ram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wmask0[b])
                        mem[ram_addr0][b*8 +: 8] <= ram_din0[b*8 +: 8];
            end else begin
                ram_dout0 <= mem[ram_addr0];
            end
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endfunction

    function automatic void push(int p, logic w, logic [31:0] d, int c);
        exp_t e;
        e.port = p;
        e.we   = w;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!ram_csb0) begin
                csb_cnt  = csb_cnt + 1;
                csb_cyc  = cyc_n;
                iss_web  = ram_web0;
                iss_mask = ram_wmask0;
                iss_addr = ram_addr0;
                iss_din  = ram_din0;
            end
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_ack: got ack {%b,%b} expected none (cycle %0d)",
                             ack1, ack0, cyc_n);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_port", {30'b0, ack1, ack0}, (e.port == 1) ? 32'd2 : 32'd1);
                    chk("grant_at_ack", {30'b0, grant_o}, (e.port == 1) ? 32'd2 : 32'd1);
                    chk("ack_cycle", cyc_n, e.cyc);
                    if (!e.we)
                        chk("read_data", (e.port == 1) ? rd1 : rd0, e.data);
                end
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1;
        pl_en   = 1'b0;
    endtask

    task automatic probe_clear();
        csb_cnt = 0;
        csb_cyc = -1;
    endtask

    task automatic wb_txn(input int p, input logic w, input logic [AW+1:0] a,
                          input logic [3:0] s, input logic [31:0] d);
        int   n;
        logic got;
        cyc[p]  = 1'b1;
        stb[p]  = 1'b1;
        we[p]   = w;
        adr[p]  = a;
        sel[p]  = s;
        wdat[p] = d;
        n   = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clk);
            n   = n + 1;
            got = (p == 1) ? ack1 : ack0;
        end
        if (!got) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL ack_timeout: port %0d got no ack expected one within 64 cycles", p);
        end
        @(posedge clk);
        #1;
        cyc[p] = 1'b0;
        stb[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        int t0;
        checks = 0;
        errors = 0;
        probe_clear();
        rst_n = 1'b0;
        lat   = '0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            sel[i] = '0; wdat[i] = '0; adr[i] = '0;
        end

        @(posedge clk);
        #1;
        preload(8'h05, 32'hDEADBEEF);
        preload(8'h08, 32'hAABBCCDD);
        for (int w = 8'h10; w <= 8'h15; w++)
            preload(AW'(w), 32'hC0DE0000 + w);
        preload(8'h30, 32'h12345678);
        preload(8'h31, 32'h87654321);
        preload(8'h32, 32'hCAFEF00D);

        @(negedge clk);
        chk("rst_csb", {31'b0, ram_csb0}, 32'd1);
        chk("rst_web", {31'b0, ram_web0}, 32'd1);
        chk("rst_wmask", {28'b0, ram_wmask0}, 32'd0);
        chk("rst_addr", {24'b0, ram_addr0}, 32'd0);
        chk("rst_din", ram_din0, 32'd0);
        chk("rst_acks", {30'b0, ack1, ack0}, 32'd0);
        chk("rst_dat0", rd0, 32'd0);
        chk("rst_dat1", rd1, 32'd0);
        chk("rst_grant", {30'b0, grant_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);

        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // read, lat=2
        lat = 4'd2;
        probe_clear();
        t0 = cyc_n;
        push(0, 1'b0, 32'hDEADBEEF, t0 + 4);
        wb_txn(0, 1'b0, 10'h014, 4'hF, 32'h0);
        chk("rd_csb_count", csb_cnt, 1);
        chk("rd_csb_cycle", csb_cyc, t0 + 1);
        chk("rd_web", {31'b0, iss_web}, 32'd1);
        chk("rd_addr", {24'b0, iss_addr}, 32'h05);
        chk("rd_dat1_shared", rd1, 32'hDEADBEEF);

        // byte write then readback
        probe_clear();
        t0 = cyc_n;
        push(1, 1'b1, 32'h0, t0 + 2);
        wb_txn(1, 1'b1, 10'h020, 4'b0101, 32'h11223344);
        chk("wr_csb_cycle", csb_cyc, t0 + 1);
        chk("wr_web", {31'b0, iss_web}, 32'd0);
        chk("wr_wmask", {28'b0, iss_mask}, 32'h5);
        chk("wr_addr", {24'b0, iss_addr}, 32'h08);
        chk("wr_din", iss_din, 32'h11223344);
        chk("wr_wmask_cleared", {28'b0, ram_wmask0}, 32'd0);
        chk("wr_grant_cleared", {30'b0, grant_o}, 32'd0);
        chk("wr_busy_cleared", {31'b0, busy_o}, 32'd0);
        lat = 4'd1;
        t0 = cyc_n;
        push(1, 1'b0, 32'hAA22CC44, t0 + 3);
        wb_txn(1, 1'b0, 10'h020, 4'hF, 32'h0);

        // simultaneous requests, 3 reads each, lat=1
        t0 = cyc_n;
        for (int k = 0; k < 6; k++)
            push(k % 2, 1'b0, 32'hC0DE0010 + k, t0 + 3 + 4 * k);
        fork
            for (int k = 0; k < 3; k++)
                wb_txn(0, 1'b0, AW'(8'h10 + 2 * k) << 2, 4'hF, 32'h0);
            for (int k = 0; k < 3; k++)
                wb_txn(1, 1'b0, AW'(8'h11 + 2 * k) << 2, 4'hF, 32'h0);
        join

        // latency boundaries
        lat = 4'd0;
        t0 = cyc_n;
        push(0, 1'b0, 32'h12345678, t0 + 2);
        wb_txn(0, 1'b0, 10'h0C0, 4'hF, 32'h0);
        lat = 4'd15;
        t0 = cyc_n;
        push(1, 1'b0, 32'h87654321, t0 + 17);
        wb_txn(1, 1'b0, 10'h0C4, 4'hF, 32'h0);
        lat = 4'd4;
        t0 = cyc_n;
        push(0, 1'b0, 32'hCAFEF00D, t0 + 6);
        fork
            wb_txn(0, 1'b0, 10'h0C8, 4'hF, 32'h0);
            begin
                repeat (3) @(posedge clk);
                #1;
                lat = 4'd3;
            end
        join

        // abort during WAIT with M1 pending
        lat = 4'd4;
        probe_clear();
        t0 = cyc_n;
        push(1, 1'b1, 32'h0, t0 + 6);
        fork
            begin
                cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
                adr[0] = 10'h014; sel[0] = 4'hF;
                repeat (3) @(posedge clk);
                #1;
                cyc[0] = 1'b0; stb[0] = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("abort_idle_busy", {31'b0, busy_o}, 32'd0);
            end
            begin
                @(posedge clk);
                #1;
                wb_txn(1, 1'b1, 10'h100, 4'hF, 32'h55AA55AA);
            end
        join
        chk("abort_m1_issue_cycle", csb_cyc, t0 + 5);
        lat = 4'd0;
        t0 = cyc_n;
        push(1, 1'b0, 32'h55AA55AA, t0 + 2);
        wb_txn(1, 1'b0, 10'h100, 4'hF, 32'h0);

        // reset during ISSUE
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
        adr[0] = 10'h140; sel[0] = 4'hF; wdat[0] = 32'h01010101;
        @(posedge clk);
        #3;
        chk("pre_rst_in_issue", {31'b0, ram_csb0}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_csb", {31'b0, ram_csb0}, 32'd1);
        chk("mid_rst_grant", {30'b0, grant_o}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        chk("mid_rst_web", {31'b0, ram_web0}, 32'd1);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // after reset M0 wins the first tie again
        lat = 4'd2;
        t0 = cyc_n;
        push(0, 1'b1, 32'h0, t0 + 2);
        push(1, 1'b0, 32'hDEADBEEF, t0 + 7);
        fork
            wb_txn(0, 1'b1, 10'h180, 4'hF, 32'h0BADF00D);
            wb_txn(1, 1'b0, 10'h014, 4'hF, 32'h0);
        join
        lat = 4'd0;
        t0 = cyc_n;
        push(1, 1'b0, 32'h0BADF00D, t0 + 2);
        wb_txn(1, 1'b0, 10'h180, 4'hF, 32'h0);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
